// File: rtl/frequency_period_readout.sv
// Snapshots one row of pixel PERIOD words on a capture strobe and streams the
// snapshot out as bytes over valid/ready: pixel 0 first, each word MSB byte first.
module frequency_period_readout #(
    parameter int NUM_PIXELS   = 8,
    parameter int COUNTER_BITS = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_PIXELS*COUNTER_BITS-1:0] period_i,
    input  logic                               capture_i,
    output logic [7:0]                         dout_o,
    output logic                               dout_valid_o,
    input  logic                               dout_ready_i,
    output logic                               dout_first_o,
    output logic                               dout_last_o,
    output logic                               busy_o,
    output logic                               overrun_o,
    input  logic                               clear_overrun_i
);
    localparam int BPW    = COUNTER_BITS / 8;
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int BYTE_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                                  state_q;
    logic [NUM_PIXELS-1:0][COUNTER_BITS-1:0] snap_q;
    logic [PIX_W-1:0]                        pix_q;
    logic [BYTE_W-1:0]                       byte_q;
    logic                                    overrun_q;

    logic               send;
    logic               fire;
    logic               at_first;
    logic               at_last;
    logic               overrun_set;
    logic [BPW-1:0][7:0] word;

    assign send     = (state_q == S_SEND);
    assign fire     = send && dout_ready_i;
    assign at_first = (pix_q == '0) && (byte_q == '0);
    assign at_last  = (pix_q == PIX_W'(NUM_PIXELS - 1)) && (byte_q == BYTE_W'(BPW - 1));
    // A capture is only accepted when it coincides with the final byte leaving.
    assign overrun_set = send && capture_i && !(fire && at_last);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            pix_q     <= '0;
            byte_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (capture_i) begin
                        state_q <= S_SEND;
                        snap_q  <= period_i;
                        pix_q   <= '0;
                        byte_q  <= '0;
                    end
                end
                S_SEND: begin
                    if (fire) begin
                        if (at_last) begin
                            pix_q  <= '0;
                            byte_q <= '0;
                            if (capture_i) snap_q <= period_i;
                            else           state_q <= S_IDLE;
                        end else if (byte_q == BYTE_W'(BPW - 1)) begin
                            byte_q <= '0;
                            pix_q  <= pix_q + 1'b1;
                        end else begin
                            byte_q <= byte_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (overrun_set)          overrun_q <= 1'b1;
            else if (clear_overrun_i) overrun_q <= 1'b0;
        end
    end

    assign word         = snap_q[pix_q];
    assign dout_o       = send ? word[BYTE_W'(BPW - 1) - byte_q] : 8'h00;
    assign dout_valid_o = send;
    assign dout_first_o = send && at_first;
    assign dout_last_o  = send && at_last;
    assign busy_o       = send;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_frequency_period_readout.sv
// Bench for frequency_period_readout (4 pixels x 32 bits): table-driven streams
// checked through an expected-byte scoreboard, plus overrun, back-to-back and reset sequences.
module tb_frequency_period_readout;
    localparam int NP = 4;
    localparam int CB = 32;
    localparam int NBYTES = NP * CB / 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic [NP*CB-1:0] period_i;
    logic           capture_i;
    logic [7:0]     dout_o;
    logic           dout_valid_o;
    logic           dout_ready_i;
    logic           dout_first_o;
    logic           dout_last_o;
    logic           busy_o;
    logic           overrun_o;
    logic           clear_overrun_i;

    frequency_period_readout #(.NUM_PIXELS(NP), .COUNTER_BITS(CB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .period_i(period_i), .capture_i(capture_i),
        .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .dout_first_o(dout_first_o), .dout_last_o(dout_last_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .clear_overrun_i(clear_overrun_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] period;   // pixel 3 in the top word
        logic [127:0] exp;      // expected byte stream, first byte in the top bits
        int           mode;     // 0: ready=1, 1: toggle, 2: random
        bit           iso;      // zero period_i right after capture
    } vec_t;

    typedef struct {
        logic [7:0] b;
        bit         first;
        bit         last;
    } sb_t;

    vec_t tbl[5];
    sb_t  q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [127:0] e);
        sb_t s;
        for (int k = 0; k < NBYTES; k++) begin
            s.b     = e[127 - 8*k -: 8];
            s.first = (k == 0);
            s.last  = (k == NBYTES - 1);
            q.push_back(s);
        end
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},  dout_o, 0);
        chk({tag, "_valid"}, dout_valid_o, 0);
        chk({tag, "_first"}, dout_first_o, 0);
        chk({tag, "_last"},  dout_last_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_ovr"},   overrun_o, 0);
    endtask

    // Runs one stream; optionally injects a capture (and clear) after cap_at
    // accepted bytes, chains a second snapshot (b2b), or resets after rst_at bytes.
    task automatic run(input vec_t v, input int cap_at, input bit capclr, input bit b2b,
                       input logic [127:0] p2, input logic [127:0] e2, input int rst_at);
        int pops = 0;
        int cyc = 0;
        bit injected = 0;
        bit pv = 0, pr = 0, pf = 0, pl = 0;
        logic [7:0] pd = 8'h00;
        sb_t e;
        @(posedge clk_i); #1;
        period_i = v.period;
        capture_i = 1'b1;
        dout_ready_i = rdy(v.mode, 0);
        push_stream(v.exp);
        @(posedge clk_i); #1;
        capture_i = 1'b0;
        if (v.iso) period_i = '0;
        while (q.size() > 0 && cyc < 400) begin
            @(negedge clk_i);
            chk("valid", dout_valid_o, 1);
            chk("busy", busy_o, 1);
            if (pv && !pr) begin
                chk("hold_dout", dout_o, pd);
                chk("hold_first", dout_first_o, pf);
                chk("hold_last", dout_last_o, pl);
            end
            pv = dout_valid_o; pr = dout_ready_i; pd = dout_o; pf = dout_first_o; pl = dout_last_o;
            if (dout_valid_o && dout_ready_i) begin
                e = q.pop_front();
                chk("dout", dout_o, e.b);
                chk("first", dout_first_o, e.first);
                chk("last", dout_last_o, e.last);
                pops++;
            end
            @(posedge clk_i); #1;
            capture_i = 1'b0;
            clear_overrun_i = 1'b0;
            cyc++;
            dout_ready_i = rdy(v.mode, cyc);
            if (rst_at >= 0 && pops == rst_at) begin
                rst_ni = 1'b0;
                #1;
                chk_all_zero("midrst");
                q.delete();
            end else if (!injected && pops == cap_at) begin
                injected = 1;
                capture_i = 1'b1;
                clear_overrun_i = capclr;
                if (b2b) begin
                    period_i = p2;
                    push_stream(e2);
                end
            end
        end
        if (cyc >= 400) begin
            chk("stream_timeout", 32'(q.size()), 0);
            q.delete();
        end
        capture_i = 1'b0;
        clear_overrun_i = 1'b0;
        @(negedge clk_i);
        chk("end_busy", busy_o, 0);
        chk("end_valid", dout_valid_o, 0);
    endtask

    task automatic pulse_clear();
        @(posedge clk_i); #1;
        clear_overrun_i = 1'b1;
        @(posedge clk_i); #1;
        clear_overrun_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        tbl[0] = '{128'hDDEEFF00_99AABBCC_55667788_11223344,
                   128'h11223344_55667788_99AABBCC_DDEEFF00, 0, 1'b0};
        tbl[1] = '{128'hDDEEFF00_99AABBCC_55667788_11223344,
                   128'h11223344_55667788_99AABBCC_DDEEFF00, 1, 1'b1};
        tbl[2] = '{128'h0, 128'h0, 2, 1'b0};
        tbl[3] = '{{128{1'b1}}, {128{1'b1}}, 0, 1'b1};
        tbl[4] = '{128'h00000001_80000000_FFFFFFFE_01234567,
                   128'h01234567_FFFFFFFE_80000000_00000001, 2, 1'b1};

        rst_ni = 1'b0;
        capture_i = 1'b0;
        period_i = '0;
        dout_ready_i = 1'b0;
        clear_overrun_i = 1'b0;
        #3;
        chk_all_zero("rst");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        dout_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("idle_valid", dout_valid_o, 0);
            chk("idle_busy", busy_o, 0);
        end

        for (int i = 0; i < 5; i++) begin
            run(tbl[i], -1, 1'b0, 1'b0, '0, '0, -1);
            chk("tbl_ovr", overrun_o, 0);
        end

        // Capture while byte 5 is presented: ignored, flags overrun.
        run(tbl[0], 5, 1'b0, 1'b0, '0, '0, -1);
        chk("ovr_set", overrun_o, 1);
        pulse_clear();
        chk("ovr_clr", overrun_o, 0);

        // Capture together with clear mid-stream: set wins.
        run(tbl[0], 6, 1'b1, 1'b0, '0, '0, -1);
        chk("ovr_set_wins", overrun_o, 1);
        pulse_clear();
        chk("ovr_clr2", overrun_o, 0);

        // Capture coincident with the final byte: seamless second snapshot.
        run(tbl[0], NBYTES - 1, 1'b0, 1'b1,
            128'h00000004_00000003_00000002_00000001,
            128'h00000001_00000002_00000003_00000004, -1);
        chk("b2b_ovr", overrun_o, 0);

        // Reset after 7 bytes, then a fresh stream from pixel 0.
        run(tbl[0], -1, 1'b0, 1'b0, '0, '0, 7);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_valid", dout_valid_o, 0);
        run(tbl[4], -1, 1'b0, 1'b0, '0, '0, -1);
        chk("final_ovr", overrun_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frequency_period_readout.md
# frequency_period_readout

Snapshot-and-stream stage directly downstream of the per-pixel `frequency_counter` array. On a `CAPTURE` strobe it latches the `PERIOD` word of every pixel in a row. It then streams the snapshot out as bytes over a valid/ready interface, which replaces bench-side direct probing of the wide `TIME_PERIOD` bus with a narrow readout port suitable for the chip pins.

## Interface
- `NUM_PIXELS`, default 8: pixels per row, i.e. the number of counters feeding this block.
- `COUNTER_BITS`, default 32: width of each `PERIOD` word. Must be a multiple of 8 and at least 8.
- `CLK`, in, 1: single clock.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `PERIOD_IN`, in, `NUM_PIXELS*COUNTER_BITS`: pixel i occupies `[i*COUNTER_BITS +: COUNTER_BITS]`.
- `CAPTURE`, in, 1: single-cycle request to snapshot `PERIOD_IN` and start a stream.
- `DOUT`, out, 8: current output byte.
- `DOUT_VALID`, out, 1: `DOUT` holds a byte.
- `DOUT_READY`, in, 1: consumer accepts the byte.
- `DOUT_FIRST`, out, 1: marks the first byte of a snapshot.
- `DOUT_LAST`, out, 1: marks the final byte of a snapshot.
- `BUSY`, out, 1: high while a snapshot is streaming.
- `OVERRUN`, out, 1: sticky flag for a rejected `CAPTURE`.
- `CLEAR_OVERRUN`, in, 1: clears `OVERRUN`.

## Operation
- State machine has two states:
  - IDLE: `BUSY`=0, `DOUT_VALID`=0.
  - SEND: `BUSY`=1, `DOUT_VALID`=1.
- IDLE → SEND: `CAPTURE`=1 at a rising edge. At that same edge:
  - the whole `PERIOD_IN` is latched into an internal snapshot register;
  - pixel index and byte index reset to 0.
- Byte order:
  - pixel 0 first, ascending pixel index;
  - within a word, MSB byte first.
  - Total bytes per snapshot are `NUM_PIXELS*COUNTER_BITS/8`.
- Output source:
  - `DOUT` = snapshot[pixel][byte], taken from the snapshot only.
  - Changes on `PERIOD_IN` after capture have no effect on the stream.
- Handshake:
  - A transfer occurs at an edge where `DOUT_VALID && DOUT_READY`.
  - Byte index advances. When it wraps from the last byte of a word to 0, the pixel index increments.
- `DOUT_FIRST` = 1 only while pixel=0 and byte=0.
- `DOUT_LAST` = 1 only while pixel=`NUM_PIXELS`-1 and byte=last.
- Transfer of the `DOUT_LAST` byte:
  - without a coincident accepted `CAPTURE`: go to IDLE;
  - with `CAPTURE`=1 in that same cycle: take a new snapshot and stay in SEND with indices reset. There is no bubble, and `DOUT_FIRST` is asserted on the next cycle. `OVERRUN` is not set.
- `CAPTURE` in SEND at any other cycle:
  - ignored; the snapshot and stream are unaffected;
  - `OVERRUN` is set at that edge.
- `OVERRUN` clear and set rules:
  - `CLEAR_OVERRUN`=1 clears it at the edge.
  - If set and clear occur in the same cycle, set wins.
- Values are passed verbatim, including 0 (no edge measured) and all-ones (saturated counter).

## Timing
- Reset (`RST_N`=0) acts immediately, without waiting for a clock edge:
  - state IDLE, indices 0, snapshot 0;
  - `DOUT`=0, `DOUT_VALID`=0, `DOUT_FIRST`=0, `DOUT_LAST`=0, `BUSY`=0, `OVERRUN`=0.
- Reset mid-stream aborts the stream and discards the snapshot. After release the block is in IDLE, and the first `CAPTURE` starts a fresh stream.
- Latency: `CAPTURE` sampled at edge k → `DOUT_VALID`=1 with the first byte from edge k through edge k+1.
- Throughput: 1 byte per cycle while `DOUT_READY`=1, with no bubbles between words.
- Backpressure: while `DOUT_VALID`=1 and `DOUT_READY`=0, all of these hold stable:
  - `DOUT`, `DOUT_FIRST`, `DOUT_LAST`;
  - the indices.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `DOUT_READY` or `CAPTURE` to outputs.
- Minimum stream with `DOUT_READY` held 1: `NUM_PIXELS*COUNTER_BITS/8` cycles. `BUSY` falls at the edge that transfers the last byte.

## Test plan
All scenarios use `NUM_PIXELS`=4, `COUNTER_BITS`=32.
- **Reset:** assert `RST_N`=0 → all outputs 0; with no `CAPTURE`, `DOUT_VALID` stays 0.
- **Basic stream:** `PERIOD_IN` = {0xDDEEFF00, 0x99AABBCC, 0x55667788, 0x11223344} (pixel 3..0), `CAPTURE` pulse, `DOUT_READY`=1 → 16 consecutive bytes 11 22 33 44 55 66 77 88 99 AA BB CC DD EE FF 00. `DOUT_FIRST` is 1 only on 0x11, `DOUT_LAST` is 1 only on 0x00, and `BUSY` drops after 16 cycles.
- **Backpressure and isolation:** same data, `DOUT_READY` toggling 1/0, and `PERIOD_IN` changed to all-0 after capture → same 16-byte sequence. `DOUT` holds whenever `DOUT_READY`=0.
- **Overrun:** `CAPTURE` at byte 5 → stream unchanged and `OVERRUN`=1. Asserting `CAPTURE` and `CLEAR_OVERRUN` together gives `OVERRUN`=1. A later `CLEAR_OVERRUN` alone gives `OVERRUN`=0.
- **Back-to-back:** `CAPTURE` coincident with the `DOUT_LAST` transfer, new `PERIOD_IN` = {4, 3, 2, 1} → next cycle `DOUT`=0x00 with `DOUT_FIRST`=1, bytes 00 00 00 01 … 00 00 00 04, `BUSY` continuously 1, `OVERRUN`=0.
- **Mid-stream reset:** `RST_N` low at byte 7 → outputs 0 immediately. After release, a new `CAPTURE` streams from pixel 0 with `DOUT_FIRST`=1.
